// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the instruction-fetch / memory-stage bus arbiter:
// the latched bus request, the arbiter state and the requester identity.
package memory_port_arbiter_pkg;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_enable;
    } MemBusRequest_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } MemArbState_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_IF   = 2'd1,
        GRANT_MEM  = 2'd2
    } MemRequester_t;

    // Instruction fetches are always full-word reads.
    function automatic MemBusRequest_t if_read_request(input logic [31:0] addr);
        MemBusRequest_t r;
        r.write       = 1'b0;
        r.addr        = addr;
        r.wdata       = '0;
        r.byte_enable = 4'b1111;
        return r;
    endfunction

endpackage

// File: rtl/memory_port_arbiter.sv
// Shares one memory bus between instruction fetch and the memory stage,
// one outstanding transaction at a time, routing each response to its issuer.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_IF_ReqValid,
    input  logic [31:0] i_IF_Addr,
    output logic        o_IF_ReqReady,
    input  logic        i_IF_Flush,
    output logic        o_IF_RspValid,
    output logic [31:0] o_IF_RspData,
    input  logic        i_MEM_ReqValid,
    input  logic        i_MEM_Write,
    input  logic [31:0] i_MEM_Addr,
    input  logic [31:0] i_MEM_WData,
    input  logic [3:0]  i_MEM_ByteEnable,
    output logic        o_MEM_ReqReady,
    output logic        o_MEM_RspValid,
    output logic [31:0] o_MEM_RspData,
    output logic        o_Bus_ReqValid,
    output logic        o_Bus_Write,
    output logic [31:0] o_Bus_Addr,
    output logic [31:0] o_Bus_WData,
    output logic [3:0]  o_Bus_ByteEnable,
    input  logic        i_Bus_ReqReady,
    input  logic        i_Bus_RspValid,
    input  logic [31:0] i_Bus_RspData
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    MemArbState_t   state_reg, state_next;
    MemRequester_t  grant_reg, grant_next;
    MemRequester_t  sel_grant;
    MemBusRequest_t req_reg, req_next;
    logic [CW-1:0]  starve_reg, starve_next;
    logic           flush_reg, flush_next;
    logic           if_rsp_reg, if_rsp_next;
    logic           mem_rsp_reg, mem_rsp_next;
    logic [31:0]    rsp_data_reg, rsp_data_next;

    // Grant selection: MEM wins contention until IF has lost STARVE_LIMIT times.
    always_comb begin
        sel_grant = GRANT_NONE;
        if (state_reg == IDLE && !i_Reset) begin
            if (i_IF_ReqValid && (!i_MEM_ReqValid || starve_reg == LIMIT))
                sel_grant = GRANT_IF;
            else if (i_MEM_ReqValid)
                sel_grant = GRANT_MEM;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg    <= IDLE;
            grant_reg    <= GRANT_NONE;
            req_reg      <= '0;
            starve_reg   <= '0;
            flush_reg    <= 1'b0;
            if_rsp_reg   <= 1'b0;
            mem_rsp_reg  <= 1'b0;
            rsp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            req_reg      <= req_next;
            starve_reg   <= starve_next;
            flush_reg    <= flush_next;
            if_rsp_reg   <= if_rsp_next;
            mem_rsp_reg  <= mem_rsp_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        req_next      = req_reg;
        starve_next   = starve_reg;
        flush_next    = flush_reg;
        if_rsp_next   = 1'b0;
        mem_rsp_next  = 1'b0;
        rsp_data_next = rsp_data_reg;
        case (state_reg)
            IDLE: begin
                if (sel_grant == GRANT_IF) begin
                    state_next  = REQ;
                    grant_next  = GRANT_IF;
                    req_next    = if_read_request(i_IF_Addr);
                    starve_next = '0;
                    flush_next  = i_IF_Flush;
                end else if (sel_grant == GRANT_MEM) begin
                    state_next          = REQ;
                    grant_next          = GRANT_MEM;
                    req_next.write       = i_MEM_Write;
                    req_next.addr        = i_MEM_Addr;
                    req_next.wdata       = i_MEM_WData;
                    req_next.byte_enable = i_MEM_ByteEnable;
                    flush_next          = 1'b0;
                    if (i_IF_ReqValid && starve_reg != LIMIT)
                        starve_next = starve_reg + CW'(1);
                end
            end
            REQ: begin
                if (grant_reg == GRANT_IF && i_IF_Flush)
                    flush_next = 1'b1;
                if (i_Bus_ReqReady)
                    state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (grant_reg == GRANT_IF && i_IF_Flush)
                    flush_next = 1'b1;
                if (i_Bus_RspValid) begin
                    state_next    = IDLE;
                    grant_next    = GRANT_NONE;
                    flush_next    = 1'b0;
                    rsp_data_next = req_reg.write ? 32'd0 : i_Bus_RspData;
                    // A flush arriving with the response still kills it.
                    if_rsp_next   = (grant_reg == GRANT_IF) && !flush_reg && !i_IF_Flush;
                    mem_rsp_next  = (grant_reg == GRANT_MEM);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = GRANT_NONE;
            end
        endcase
    end

    always_comb begin
        o_IF_ReqReady    = (sel_grant == GRANT_IF);
        o_MEM_ReqReady   = (sel_grant == GRANT_MEM);
        o_Bus_ReqValid   = (state_reg == REQ);
        o_Bus_Write      = (state_reg == REQ) ? req_reg.write       : 1'b0;
        o_Bus_Addr       = (state_reg == REQ) ? req_reg.addr        : 32'd0;
        o_Bus_WData      = (state_reg == REQ) ? req_reg.wdata       : 32'd0;
        o_Bus_ByteEnable = (state_reg == REQ) ? req_reg.byte_enable : 4'd0;
        o_IF_RspValid    = if_rsp_reg;
        o_IF_RspData     = if_rsp_reg ? rsp_data_reg : 32'd0;
        o_MEM_RspValid   = mem_rsp_reg;
        o_MEM_RspData    = mem_rsp_reg ? rsp_data_reg : 32'd0;
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a transaction-level model is
// compared against the outputs every cycle, plus literal spot checks.
module tb_memory_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_valid = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_be = '0;
    logic        bus_ready = 1'b0, bus_rsp = 1'b0;
    logic [31:0] bus_data = '0;

    logic        if_ready, if_rsp_valid, mem_ready, mem_rsp_valid;
    logic [31:0] if_rsp_data, mem_rsp_data;
    logic        b_valid, b_write;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;

    memory_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .i_Clock(clk), .i_Reset(rst),
        .i_IF_ReqValid(if_valid), .i_IF_Addr(if_addr), .o_IF_ReqReady(if_ready),
        .i_IF_Flush(if_flush), .o_IF_RspValid(if_rsp_valid), .o_IF_RspData(if_rsp_data),
        .i_MEM_ReqValid(mem_valid), .i_MEM_Write(mem_write), .i_MEM_Addr(mem_addr),
        .i_MEM_WData(mem_wdata), .i_MEM_ByteEnable(mem_be), .o_MEM_ReqReady(mem_ready),
        .o_MEM_RspValid(mem_rsp_valid), .o_MEM_RspData(mem_rsp_data),
        .o_Bus_ReqValid(b_valid), .o_Bus_Write(b_write), .o_Bus_Addr(b_addr),
        .o_Bus_WData(b_wdata), .o_Bus_ByteEnable(b_be),
        .i_Bus_ReqReady(bus_ready), .i_Bus_RspValid(bus_rsp), .i_Bus_RspData(bus_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;
    int grants[$];
    int if_pulses = 0;
    int mem_pulses = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one in-flight request, its owner, whether the bus
    // took it yet, whether IF asked to drop it, and the pending reply pulse.
    bit          m_busy = 0, m_sent = 0, m_kill = 0;
    int          m_owner = 0;
    int          m_wins = 0;
    bit          m_write = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;
    bit          m_pif = 0, m_pmem = 0;
    logic [31:0] m_pdata = '0;

    function automatic bit want_if();
        return !rst && !m_busy && if_valid && (!mem_valid || m_wins >= STARVE);
    endfunction

    function automatic bit want_mem();
        return !rst && !m_busy && mem_valid && !want_if();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_sent <= 0; m_kill <= 0; m_owner <= 0; m_wins <= 0;
            m_write <= 0; m_addr <= '0; m_wdata <= '0; m_be <= '0;
            m_pif <= 0; m_pmem <= 0; m_pdata <= '0;
        end else begin
            m_pif  <= 0;
            m_pmem <= 0;
            if (!m_busy) begin
                if (want_if()) begin
                    m_busy <= 1; m_sent <= 0; m_owner <= 1; m_kill <= if_flush;
                    m_write <= 0; m_addr <= if_addr; m_wdata <= '0; m_be <= 4'hF;
                    m_wins <= 0;
                end else if (want_mem()) begin
                    m_busy <= 1; m_sent <= 0; m_owner <= 2; m_kill <= 0;
                    m_write <= mem_write; m_addr <= mem_addr; m_wdata <= mem_wdata; m_be <= mem_be;
                    if (if_valid) m_wins <= (m_wins + 1 > STARVE) ? STARVE : m_wins + 1;
                end
            end else begin
                if (if_flush && m_owner == 1) m_kill <= 1;
                if (!m_sent) begin
                    if (bus_ready) m_sent <= 1;
                end else if (bus_rsp) begin
                    m_busy  <= 0;
                    m_kill  <= 0;
                    m_pif   <= (m_owner == 1) && !m_kill && !if_flush;
                    m_pmem  <= (m_owner == 2);
                    m_pdata <= m_write ? 32'd0 : bus_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [79:0] exp_bus;
            exp_bus = (m_busy && !m_sent) ? {10'd0, 1'b1, m_write, m_addr, m_wdata, m_be} : 80'd0;
            chk("if_ready", 80'(if_ready), 80'(want_if()));
            chk("mem_ready", 80'(mem_ready), 80'(want_mem()));
            chk("bus_req", {10'd0, b_valid, b_write, b_addr, b_wdata, b_be}, exp_bus);
            chk("if_rsp", {47'd0, if_rsp_valid, if_rsp_data}, {47'd0, m_pif, m_pif ? m_pdata : 32'd0});
            chk("mem_rsp", {47'd0, mem_rsp_valid, mem_rsp_data}, {47'd0, m_pmem, m_pmem ? m_pdata : 32'd0});
            if (if_ready)  grants.push_back(1);
            if (mem_ready) grants.push_back(2);
            if (if_rsp_valid)  if_pulses++;
            if (mem_rsp_valid) mem_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [79:0] all_out;
    assign all_out = {if_ready, mem_ready, if_rsp_valid, mem_rsp_valid, b_valid, b_write,
                      b_be, if_rsp_data, mem_rsp_data} ^ {38'd0, b_addr ^ b_wdata, 10'd0};

    initial begin
        int exp_order[11];
        int base_if;
        int base_mem;
        exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2};
        rst = 1'b1;
        step();
        chk_en = 1;
        step();
        chk("reset_outputs_zero", all_out, 80'd0);
        rst = 1'b0;
        step();

        // IF-only fetch at minimum latency
        if_valid = 1; if_addr = 32'h10; bus_ready = 1;
        settle(); chk("if_accept_N", 80'(if_ready), 80'd1);
        step(); if_valid = 0;
        settle(); chk("if_bus_N1", {47'd0, b_valid, b_addr}, {47'd0, 1'b1, 32'h10});
        step(); bus_rsp = 1; bus_data = 32'h13;
        step(); bus_rsp = 0;
        settle(); chk("if_rsp_N3", {46'd0, if_rsp_valid, mem_rsp_valid, if_rsp_data}, {46'd0, 2'b10, 32'h13});
        step();
        settle(); chk("if_rsp_one_cycle", 80'(if_rsp_valid), 80'd0);

        // Continuous contention
        grants.delete();
        if_valid = 1; if_addr = 32'h44; mem_valid = 1; mem_write = 0; mem_addr = 32'h80;
        bus_ready = 1; bus_rsp = 1; bus_data = 32'h1234_5678;
        repeat (33) step();
        if_valid = 0; mem_valid = 0;
        step(); bus_rsp = 0;
        chk("grant_count", 80'(grants.size()), 80'd11);
        for (int i = 0; i < 11 && i < grants.size(); i++)
            chk($sformatf("grant_order[%0d]", i), 80'(grants[i]), 80'(exp_order[i]));

        // Store with back-pressure: fields must hold while bus is not ready
        step();
        mem_valid = 1; mem_write = 1; mem_addr = 32'h100; mem_wdata = 32'hCAFEBABE; mem_be = 4'b0011;
        bus_ready = 0;
        settle(); chk("store_accept", 80'(mem_ready), 80'd1);
        step(); mem_valid = 0; mem_addr = 32'hBAD0; mem_wdata = 32'h0; mem_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("store_hold", {10'd0, b_valid, b_write, b_addr, b_wdata, b_be},
                {10'd0, 1'b1, 1'b1, 32'h100, 32'hCAFEBABE, 4'b0011});
            step();
        end
        bus_ready = 1;
        step(); bus_ready = 0; bus_rsp = 1; bus_data = 32'hFFFF_FFFF;
        step(); bus_rsp = 0;
        settle(); chk("store_ack", {47'd0, mem_rsp_valid, mem_rsp_data}, {47'd0, 1'b1, 32'h0});
        step();

        // Flush in WAIT_RSP, then flush on the accept cycle
        base_if = if_pulses;
        if_valid = 1; if_addr = 32'h20; bus_ready = 1;
        step(); if_valid = 0;
        step(); if_flush = 1;
        step(); if_flush = 0; bus_rsp = 1; bus_data = 32'hDEADBEEF;
        step(); bus_rsp = 0;
        if_valid = 1; if_addr = 32'h24; if_flush = 1;
        settle(); chk("post_flush_accept", 80'(if_ready), 80'd1);
        step(); if_valid = 0; if_flush = 0;
        step(); bus_rsp = 1; bus_data = 32'h0BAD_F00D;
        step(); bus_rsp = 0;
        step();
        chk("flush_no_if_rsp", 80'(if_pulses - base_if), 80'd0);
        mem_valid = 1; mem_write = 0; mem_addr = 32'h200;
        settle(); chk("mem_after_flush", 80'(mem_ready), 80'd1);
        step(); mem_valid = 0;
        step(); bus_rsp = 1; bus_data = 32'h55;
        step(); bus_rsp = 0;
        settle(); chk("mem_load_data", {47'd0, mem_rsp_valid, mem_rsp_data}, {47'd0, 1'b1, 32'h55});
        step();

        // Reset in WAIT_RSP of a MEM load
        base_mem = mem_pulses;
        mem_valid = 1; mem_addr = 32'h300;
        step(); mem_valid = 0;
        step(); rst = 1;
        settle(); chk("reset_mid_op_zero", all_out, 80'd0);
        step(); rst = 0; bus_rsp = 1; bus_data = 32'h77;
        step(); bus_rsp = 0;
        step();
        chk("reset_drops_rsp", 80'(mem_pulses - base_mem), 80'd0);
        if_valid = 1; if_addr = 32'h40;
        settle(); chk("if_after_reset_accept", 80'(if_ready), 80'd1);
        step(); if_valid = 0;
        settle(); chk("if_after_reset_bus", {47'd0, b_valid, b_addr}, {47'd0, 1'b1, 32'h40});
        step(); bus_rsp = 1; bus_data = 32'h99;
        step(); bus_rsp = 0;
        settle(); chk("if_after_reset_rsp", {47'd0, if_rsp_valid, if_rsp_data}, {47'd0, 1'b1, 32'h99});
        step();

        // Spurious bus response while idle
        base_if = if_pulses; base_mem = mem_pulses;
        bus_ready = 0; bus_rsp = 1; bus_data = 32'h5A5A;
        repeat (3) step();
        bus_rsp = 0;
        step();
        chk("spurious_no_rsp", 80'((if_pulses - base_if) + (mem_pulses - base_mem)), 80'd0);
        mem_valid = 1; mem_addr = 32'h400;
        settle(); chk("spurious_still_idle", 80'(mem_ready), 80'd1);
        step(); mem_valid = 0; bus_ready = 1;
        step(); bus_rsp = 1; bus_data = 32'h66;
        step(); bus_rsp = 0;
        repeat (3) step();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
